// File: rtl/ham_pkg.sv
// Shared helpers for the extended-Hamming (SECDED) code family: code geometry
// and the classification type carried down the decoder pipeline.
package ham_pkg;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_SINGLE,
    ERR_DOUBLE
  } err_kind_t;

  // Smallest r such that 2^r >= data_w + r + 1.
  function automatic int calc_par_w(input int data_w);
    for (int r = 1; r < 31; r++) begin
      if ((1 << r) >= data_w + r + 1) return r;
    end
    return 31;
  endfunction

  function automatic bit is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Data bits fill the non-power-of-two positions in ascending order.
  function automatic int data_pos(input int k);
    int seen;
    seen = 0;
    for (int p = 1; p < 4096; p++) begin
      if (!is_pow2(p)) begin
        if (seen == k) return p;
        seen++;
      end
    end
    return 0;
  endfunction

endpackage

// File: rtl/ham_syndrome_calc.sv
// Combinational syndrome and overall-parity calculation for an extended
// Hamming codeword; shared by the decoder and the encoder-check path.
module ham_syndrome_calc
  import ham_pkg::*;
#(
  parameter  int DATA_W = 4,
  localparam int PAR_W  = calc_par_w(DATA_W),
  localparam int HAM_W  = DATA_W + PAR_W,
  localparam int CW_W   = HAM_W + 1
) (
  input  logic [CW_W-1:0]  cw_i,
  output logic [PAR_W-1:0] syn_o,
  output logic             par_o
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    syn_o = '0;
    for (int i = 1; i <= HAM_W; i++) begin
      if (cw_i[i-1]) syn_o = syn_o ^ PAR_W'(i);
    end
    par_o = ^cw_i;
  end

endmodule

// File: rtl/ham_secded_dec_stream.sv
// Two-stage streaming SECDED decoder with valid/ready handshake and
// saturating corrected/uncorrectable event counters.
module ham_secded_dec_stream
  import ham_pkg::*;
#(
  parameter  int DATA_W = 4,
  parameter  int CNT_W  = 16,
  localparam int PAR_W  = calc_par_w(DATA_W),
  localparam int HAM_W  = DATA_W + PAR_W,
  localparam int CW_W   = HAM_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   cw_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PAR_W-1:0]  out_pos,
  output logic              out_err_single,
  output logic              out_err_double,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  logic              s1_full_q;
  logic [CW_W-1:0]   s1_cw_q;
  logic [PAR_W-1:0]  s1_syn_q;
  logic              s1_par_q;
  logic              s2_full_q;
  logic [DATA_W-1:0] s2_data_q;
  logic [PAR_W-1:0]  s2_pos_q;
  err_kind_t         s2_kind_q;
  logic [CNT_W-1:0]  corr_q;
  logic [CNT_W-1:0]  uncorr_q;

  logic              s1_adv;
  logic              in_fire;
  logic              out_fire;
  logic [PAR_W-1:0]  syn_d;
  logic              par_d;
  err_kind_t         kind_d;
  logic [PAR_W-1:0]  pos_d;
  logic [CW_W-1:0]   flip_mask;
  logic [CW_W-1:0]   cw_fix;
  logic [DATA_W-1:0] data_d;

  assign s1_adv   = !s2_full_q || out_ready;
  assign in_ready = !rst && (!s1_full_q || s1_adv);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_full_q && out_ready;

  ham_syndrome_calc #(.DATA_W(DATA_W)) u_syn (
    .cw_i  (cw_in),
    .syn_o (syn_d),
    .par_o (par_d)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      s1_full_q <= 1'b0;
      s1_cw_q   <= '0;
      s1_syn_q  <= '0;
      s1_par_q  <= 1'b0;
    end else if (in_ready) begin
      s1_full_q <= in_valid;
      if (in_valid) begin
        s1_cw_q  <= cw_in;
        s1_syn_q <= syn_d;
        s1_par_q <= par_d;
      end
    end
  end

  // Syndromes beyond HAM_W only occur in shortened codes and are uncorrectable.
  always_comb begin
    kind_d    = ERR_NONE;
    pos_d     = '0;
    flip_mask = '0;
    if (s1_par_q) begin
      if (s1_syn_q == '0) begin
        kind_d = ERR_SINGLE;
      end else if (int'(s1_syn_q) <= HAM_W) begin
        kind_d    = ERR_SINGLE;
        pos_d     = s1_syn_q;
        flip_mask = CW_W'(1) << (s1_syn_q - PAR_W'(1));
      end else begin
        kind_d = ERR_DOUBLE;
      end
    end else if (s1_syn_q != '0) begin
      kind_d = ERR_DOUBLE;
    end
  end

  assign cw_fix = s1_cw_q ^ flip_mask;

  for (genvar k = 0; k < DATA_W; k++) begin : g_extract
    assign data_d[k] = cw_fix[data_pos(k)-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_full_q <= 1'b0;
      s2_data_q <= '0;
      s2_pos_q  <= '0;
      s2_kind_q <= ERR_NONE;
    end else if (s1_adv) begin
      s2_full_q <= s1_full_q;
      if (s1_full_q) begin
        s2_data_q <= data_d;
        s2_pos_q  <= pos_d;
        s2_kind_q <= kind_d;
      end
    end
  end

  // Clear wins over a coinciding event; the event is dropped, not deferred.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      corr_q   <= '0;
      uncorr_q <= '0;
    end else if (out_fire) begin
      if (s2_kind_q == ERR_SINGLE && corr_q != '1)   corr_q   <= corr_q + CNT_W'(1);
      if (s2_kind_q == ERR_DOUBLE && uncorr_q != '1) uncorr_q <= uncorr_q + CNT_W'(1);
    end
  end

  assign out_valid      = s2_full_q;
  assign out_data       = s2_data_q;
  assign out_pos        = s2_pos_q;
  assign out_err_single = (s2_kind_q == ERR_SINGLE);
  assign out_err_double = (s2_kind_q == ERR_DOUBLE);
  assign corr_cnt       = corr_q;
  assign uncorr_cnt     = uncorr_q;

endmodule

// File: tb/tb_ham_secded_dec_stream.sv
// Directed bench for the streaming SECDED decoder (DATA_W=4, CNT_W=2 so the
// counter saturation point is reachable quickly).
module tb_ham_secded_dec_stream;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] cw_in;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [2:0] out_pos;
  logic       out_err_single;
  logic       out_err_double;
  logic       cnt_clr;
  logic [1:0] corr_cnt;
  logic [1:0] uncorr_cnt;

  int checks;
  int failures;
  int exp_corr;
  int exp_uncorr;

  ham_secded_dec_stream #(.DATA_W(4), .CNT_W(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .cw_in          (cw_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_pos        (out_pos),
    .out_err_single (out_err_single),
    .out_err_double (out_err_double),
    .cnt_clr        (cnt_clr),
    .corr_cnt       (corr_cnt),
    .uncorr_cnt     (uncorr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 3) ? 3 : v + 1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; cw_in = 8'h00; out_ready = 1'b1; cnt_clr = 1'b0;
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0 0", out_valid, in_ready);
    end
    checks++;
    if ({out_data, out_pos, out_err_single, out_err_double} !== 9'd0 ||
        corr_cnt !== 2'd0 || uncorr_cnt !== 2'd0) begin
      failures++;
      $display("FAIL reset_out: data=%h pos=%0d s=%b d=%b corr=%0d uncorr=%0d want all 0",
               out_data, out_pos, out_err_single, out_err_double, corr_cnt, uncorr_cnt);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
    end
    exp_corr = 0; exp_uncorr = 0;
  endtask

  // One isolated word with out_ready held high: accept, latency, result, counters.
  task automatic send_one(input string name, input logic [7:0] cw, input logic [3:0] ed,
                          input logic [2:0] ep, input logic es, input logic edbl);
    out_ready = 1'b1; in_valid = 1'b1; cw_in = cw;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL %s_accept: in_ready=%b want 1", name, in_ready);
    end
    tick();
    in_valid = 1'b0; cw_in = 8'hxx;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL %s_latency1: out_valid=%b want 0", name, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== ed || out_pos !== ep ||
        out_err_single !== es || out_err_double !== edbl) begin
      failures++;
      $display("FAIL %s_result: v=%b data=%b pos=%0d s=%b d=%b want v=1 data=%b pos=%0d s=%b d=%b",
               name, out_valid, out_data, out_pos, out_err_single, out_err_double, ed, ep, es, edbl);
    end
    tick();
    if (es)   exp_corr   = sat_inc(exp_corr);
    if (edbl) exp_uncorr = sat_inc(exp_uncorr);
    checks++;
    if (out_valid !== 1'b0 || int'(corr_cnt) != exp_corr || int'(uncorr_cnt) != exp_uncorr) begin
      failures++;
      $display("FAIL %s_count: v=%b corr=%0d uncorr=%0d want v=0 corr=%0d uncorr=%0d",
               name, out_valid, corr_cnt, uncorr_cnt, exp_corr, exp_uncorr);
    end
  endtask

  task automatic test_clean();
    send_one("clean55", 8'h55, 4'b1011, 3'd0, 1'b0, 1'b0);
    send_one("clean33", 8'h33, 4'b0110, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic test_single();
    send_one("flip7", 8'h15, 4'b1011, 3'd7, 1'b1, 1'b0);
    send_one("flip3", 8'h51, 4'b1011, 3'd3, 1'b1, 1'b0);
    send_one("flip1", 8'h32, 4'b0110, 3'd1, 1'b1, 1'b0);
  endtask

  task automatic test_overall();
    send_one("flipP", 8'hD5, 4'b1011, 3'd0, 1'b1, 1'b0);
  endtask

  task automatic test_double();
    send_one("dbl12", 8'h56, 4'b1011, 3'd0, 1'b0, 1'b1);
    send_one("dbl56", 8'h03, 4'b0000, 3'd0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3];
    logic [3:0] e_data [3];
    logic [2:0] e_pos [3];
    logic       e_s [3];
    logic       e_d [3];
    int sent;
    int got;
    logic in_f;
    logic out_f;
    words  = '{8'h55, 8'h15, 8'h56};
    e_data = '{4'b1011, 4'b1011, 4'b1011};
    e_pos  = '{3'd0, 3'd7, 3'd0};
    e_s    = '{1'b0, 1'b1, 1'b0};
    e_d    = '{1'b0, 1'b0, 1'b1};
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
      in_valid  = (sent < 3);
      cw_in     = (sent < 3) ? words[sent] : 8'hxx;
      out_ready = (cyc < 2 || cyc >= 5);
      #1;
      if (cyc >= 2 && cyc < 5) begin
        checks++;
        if (in_ready !== 1'b0) begin
          failures++; $display("FAIL b2b_stall_ready: cyc=%0d in_ready=%b want 0", cyc, in_ready);
        end
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (out_data !== e_data[got] || out_pos !== e_pos[got] ||
            out_err_single !== e_s[got] || out_err_double !== e_d[got]) begin
          failures++;
          $display("FAIL b2b_word%0d: cyc=%0d data=%b pos=%0d s=%b d=%b want data=%b pos=%0d s=%b d=%b",
                   got, cyc, out_data, out_pos, out_err_single, out_err_double,
                   e_data[got], e_pos[got], e_s[got], e_d[got]);
        end
      end
      in_f  = in_valid && in_ready;
      out_f = out_valid && out_ready;
      if (out_f && e_s[got]) exp_corr   = sat_inc(exp_corr);
      if (out_f && e_d[got]) exp_uncorr = sat_inc(exp_uncorr);
      tick();
      if (in_f)  sent++;
      if (out_f) got++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if (sent != 3 || got != 3 || out_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_total: sent=%0d got=%0d out_valid=%b want 3 3 0", sent, got, out_valid);
    end
    checks++;
    if (int'(corr_cnt) != exp_corr || int'(uncorr_cnt) != exp_uncorr) begin
      failures++;
      $display("FAIL b2b_count: corr=%0d uncorr=%0d want %0d %0d", corr_cnt, uncorr_cnt, exp_corr, exp_uncorr);
    end
  endtask

  task automatic test_saturation();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    exp_corr = 0; exp_uncorr = 0;
    checks++;
    if (corr_cnt !== 2'd0 || uncorr_cnt !== 2'd0) begin
      failures++; $display("FAIL clr: corr=%0d uncorr=%0d want 0 0", corr_cnt, uncorr_cnt);
    end
    for (int i = 0; i < 5; i++) send_one("sat", 8'h15, 4'b1011, 3'd7, 1'b1, 1'b0);
    checks++;
    if (corr_cnt !== 2'd3) begin
      failures++; $display("FAIL sat_final: corr=%0d want 3", corr_cnt);
    end
  endtask

  task automatic test_clr_collision();
    out_ready = 1'b0; in_valid = 1'b1; cw_in = 8'h15;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_err_single !== 1'b1 || corr_cnt !== 2'd3) begin
      failures++;
      $display("FAIL clrcol_pre: v=%b s=%b corr=%0d want 1 1 3", out_valid, out_err_single, corr_cnt);
    end
    out_ready = 1'b1; cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    exp_corr = 0;
    checks++;
    if (corr_cnt !== 2'd0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL clrcol: corr=%0d v=%b want 0 0", corr_cnt, out_valid);
    end
    tick();
    checks++;
    if (corr_cnt !== 2'd0) begin
      failures++; $display("FAIL clrcol_dropped: corr=%0d want 0", corr_cnt);
    end
  endtask

  task automatic test_rst_mid();
    out_ready = 1'b0; in_valid = 1'b1; cw_in = 8'h15;
    tick();
    cw_in = 8'h56;
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL rstmid_pre: out_valid=%b want 1", out_valid);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 4'd0 || out_pos !== 3'd0 ||
        out_err_single !== 1'b0 || out_err_double !== 1'b0 ||
        corr_cnt !== 2'd0 || uncorr_cnt !== 2'd0) begin
      failures++;
      $display("FAIL rstmid: v=%b rdy=%b data=%h pos=%0d s=%b d=%b corr=%0d uncorr=%0d want all 0",
               out_valid, in_ready, out_data, out_pos, out_err_single, out_err_double, corr_cnt, uncorr_cnt);
    end
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        failures++; $display("FAIL rstmid_ghost: cycle %0d out_valid=%b want 0", i, out_valid);
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    exp_corr = 0; exp_uncorr = 0;
    test_reset();
    test_clean();
    test_single();
    test_overall();
    test_double();
    test_back_to_back();
    test_saturation();
    test_clr_collision();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ham_secded_dec_stream.md
Name: ham_secded_dec_stream

Overview:
- Parametrised streaming SECDED (extended Hamming) decoder.
- Generalises the team's combinational (7,4) Hamming decoder in three ways: any data width, an added overall-parity bit that detects double errors, and a 2-stage pipeline with valid/ready handshake and saturating error counters.
- Sits between the channel/memory read path and the data consumer.

Parameters:
- DATA_W, 4, data bits per codeword (>=1).
- CNT_W, 16, width of the corrected and uncorrectable event counters.
- Derived localparams, not overridable:
  - PAR_W: smallest r with 2^r >= DATA_W+r+1.
  - HAM_W = DATA_W+PAR_W.
  - CW_W = HAM_W+1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  codeword valid.
- in_ready  out  1  decoder can accept.
- cw_in  in  CW_W  codeword.
  - cw_in[i-1] holds Hamming position i, for i = 1..HAM_W.
  - cw_in[CW_W-1] is the overall parity bit.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_data  out  DATA_W  corrected data.
- out_pos  out  PAR_W  error position (1..HAM_W); 0 = none, or the overall parity bit is in error.
- out_err_single  out  1  single error detected and corrected.
- out_err_double  out  1  uncorrectable error.
- cnt_clr  in  1  clears both counters.
- corr_cnt  out  CNT_W  saturating count of delivered single-error words.
- uncorr_cnt  out  CNT_W  saturating count of delivered uncorrectable words.

Behaviour:
- Code layout:
  - Parity bits sit at power-of-two positions.
  - Data bits fill the remaining positions in ascending order; data[0] is at position 3.
  - Even parity throughout.
- Stage 1, on accept:
  - Register syndrome s = XOR of position indices i (1..HAM_W) whose bit is 1.
  - Register overall parity p = XOR of all CW_W bits.
  - Register the raw codeword.
- Stage 2 classification:
  - s==0, p==0: clean. out_pos=0, both flags 0.
  - p==1, 1<=s<=HAM_W: single error. Flip bit s; out_pos=s; out_err_single=1.
  - p==1, s==0: single error in the overall parity bit. Data unchanged; out_pos=0; out_err_single=1.
  - p==0, s!=0: double error. out_err_double=1; out_pos=0; out_data = uncorrected extracted data.
  - p==1, s>HAM_W (shortened codes only): uncorrectable. Treated as the double-error case.
- Flags are mutually exclusive.
- Latency: 2 cycles from an accepted input to out_valid while out_ready stays high. Throughput is 1 word/cycle.
- Handshake:
  - A transfer occurs when valid && ready on the same edge.
  - in_ready = !s1_full || s1 advancing. s1 advances when !s2_full || out_ready, so this is a full-throughput skid-free pipeline.
  - While out_valid=1 and out_ready=0, all out_* values are held stable.
  - in_valid may drop at any time without penalty.
- Counters:
  - Increment on an output transfer (out_valid && out_ready) carrying the matching flag.
  - Saturate at 2^CNT_W-1.
  - cnt_clr has priority: if an increment event coincides with cnt_clr, the counter reads 0 next cycle and the event is dropped.
- Reset:
  - Both stages empty.
  - out_valid=0, out_data=0, out_pos=0, both flags=0, both counters=0.
  - in_ready=0 during reset, 1 on the first cycle after.
  - Reset mid-stream discards all in-flight words; nothing is emitted for them.
- X on cw_in is don't-care when in_valid=0.

Decomposition:
- Package ham_pkg holds:
  - function calc_par_w(data_w).
  - function is_pow2(pos).
  - function data_pos(k), the Hamming position of data bit k.
  - Enum err_kind_t {ERR_NONE, ERR_SINGLE, ERR_DOUBLE}.
- One sub-module: ham_syndrome_calc.
  - Combinational, parametrised on DATA_W.
  - Computes s and p; instantiated in stage 1.
  - Reusable by the future encoder-check path.
- Counters and the handshake stay in the top module.

Test Plan (DATA_W=4, CW_W=8):
- Clean word: cw_in=8'h55 -> out_data=4'b1011, out_pos=0, both flags=0, out_valid exactly 2 cycles after accept.
- Flip position 7: cw_in=8'h15 -> out_data=4'b1011, out_pos=7, out_err_single=1, corr_cnt increments to 1.
- Flip the overall parity bit: cw_in=8'hD5 -> out_data=4'b1011, out_pos=0, out_err_single=1.
- Double error, positions 1 and 2 flipped: cw_in=8'h56 -> out_err_double=1, out_err_single=0, uncorr_cnt=1, corr_cnt unchanged.
- Back-pressure: stream 8'h55, 8'h15, 8'h56 back-to-back, holding out_ready=0 for 3 cycles.
  - in_ready=0 after the two stages fill; the held output stays stable.
  - Release yields the three results in order, with no loss or duplication.
- Counter edges:
  - With CNT_W=2 and five single-error words, corr_cnt saturates at 3.
  - cnt_clr asserted in the same cycle as a single-error output transfer -> corr_cnt=0.
  - rst asserted mid-stream -> out_valid=0 next cycle and the in-flight words are never emitted.
